sobel_window_former: RTL and testbench

//  Front-end controller and 3x3 window builder for the Sobel pipeline. Accepts the raster pixel

---
 rtl/sobel_window_former.sv | 119 +++++++++++
 tb/tb_sobel_window_former.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_former.sv
// Sobel front end: accepts the raster pixel stream, feeds the line-buffer chain and
// assembles the 3x3 window from its row taps, flagging windows fully inside the frame.
module sobel_window_former #(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pix_valid,
  input  logic [DATA_WIDTH-1:0]     pix_in,
  output logic                      pix_ready,
  output logic                      shift_en,
  output logic [DATA_WIDTH-1:0]     fifo_data,
  input  logic [DATA_WIDTH-1:0]     row0,
  input  logic [DATA_WIDTH-1:0]     row1,
  input  logic [DATA_WIDTH-1:0]     row2,
  output logic [9*DATA_WIDTH-1:0]   win,
  output logic                      win_valid,
  output logic [$clog2(HEIGHT)-1:0] ctr_row,
  output logic [$clog2(WIDTH)-1:0]  ctr_col,
  output logic                      frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_p [3][3];

  logic                  w_accept;
  logic                  w_last;
  logic                  w_interior;
  logic [DATA_WIDTH-1:0] w_tap [3];

  assign pix_ready  = (r_state == S_RUN) & ~start;
  assign w_accept   = pix_valid & pix_ready;
  assign shift_en   = w_accept;
  assign fifo_data  = pix_in;
  assign w_last     = (r_row == RW'(HEIGHT - 1)) && (r_col == CW'(WIDTH - 1));
  // Only columns 2.. of rows 2.. complete a window; columns 0/1 just refill after a wrap.
  assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_tap[0]   = row0;
  assign w_tap[1]   = row1;
  assign w_tap[2]   = row2;

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[(r*3+c)*DATA_WIDTH +: DATA_WIDTH] = r_p[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      win_valid  <= 1'b0;
      ctr_row    <= '0;
      ctr_col    <= '0;
      frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_p[r][c] <= '0;
        end
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        r_state <= S_RUN;
        r_col   <= '0;
        r_row   <= '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            r_p[r][c] <= '0;
          end
        end
      end else begin
        case (r_state)
          S_RUN:   if (w_accept && w_last) r_state <= S_DONE;
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= r_state;
        endcase
        if (w_accept) begin
          for (int r = 0; r < 3; r++) begin
            r_p[r][0] <= r_p[r][1];
            r_p[r][1] <= r_p[r][2];
            r_p[r][2] <= w_tap[r];
          end
          // Counters park on the last pixel until the next start.
          if (!w_last) begin
            if (r_col == CW'(WIDTH - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
          if (w_interior) begin
            win_valid <= 1'b1;
            ctr_row   <= r_row - RW'(1);
            ctr_col   <= r_col - CW'(1);
          end
          if (w_last) frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_former.sv
// Bench for sobel_window_former on a 5x4 frame with a behavioural line-buffer chain.
module tb_sobel_window_former;
  localparam int W  = 5;
  localparam int HT = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          pix_ready, shift_en, win_valid, frame_done;
  logic [DW-1:0] fifo_data, row0, row1, row2;
  logic [9*DW-1:0] win;
  logic [1:0]    ctr_row;
  logic [2:0]    ctr_col;

  sobel_window_former #(.WIDTH(W), .HEIGHT(HT), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .shift_en(shift_en), .fifo_data(fifo_data),
    .row0(row0), .row1(row1), .row2(row2), .win(win), .win_valid(win_valid),
    .ctr_row(ctr_row), .ctr_col(ctr_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Line-buffer chain: newest row is the pixel being written, older rows are W and 2W accepts back.
  logic [DW-1:0] dl [2*W] = '{default: '0};
  always @(posedge clk) begin
    if (shift_en) begin
      for (int i = 2*W-1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= fifo_data;
    end
  end
  assign row2 = fifo_data;
  assign row1 = dl[W-1];
  assign row0 = dl[2*W-1];

  int errors = 0;
  int checks = 0;

  // Reference: every accepted pixel in a global history; the frame starts at index F.
  logic [DW-1:0] H[$];
  int  G = 0, F = 0, lastg = -1, fk = 0;
  bit  running = 0, e_wv = 0, e_fd = 0;
  int  e_cr = 0, e_cc = 0;
  int  wv_cnt = 0, first_cr = -1, first_cc = -1, first_v = -1, last_cr = -1, last_cc = -1, last_v = -1;

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window after the most recent accept: column c came from accept lastg-(2-c), row r of it
  // is that pixel's image-neighbour (2-r) lines above; columns from before the frame are zero.
  function automatic logic [9*DW-1:0] exp_win();
    logic [9*DW-1:0] w = '0;
    int src, idx;
    if (lastg >= 0) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          src = lastg - (2 - c);
          idx = src - (2 - r) * W;
          if (src >= F && idx >= 0) w[(r*3+c)*DW +: DW] = H[idx];
        end
      end
    end
    return w;
  endfunction

  task automatic check_regs();
    chk("win_valid", {71'd0, win_valid}, {71'd0, e_wv});
    chk("frame_done", {71'd0, frame_done}, {71'd0, e_fd});
    chk("win", win, exp_win());
    if (e_wv) begin
      chk("ctr_row", 72'(ctr_row), 72'(e_cr));
      chk("ctr_col", 72'(ctr_col), 72'(e_cc));
    end
    if (win_valid) begin
      wv_cnt++;
      if (wv_cnt == 1) begin
        first_cr = int'(ctr_row); first_cc = int'(ctr_col); first_v = int'(win[4*DW +: DW]);
      end
      last_cr = int'(ctr_row); last_cc = int'(ctr_col); last_v = int'(win[4*DW +: DW]);
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [DW-1:0] d);
    bit acc;
    int r, c;
    start = s; pix_valid = v; pix_in = d;
    #1;
    acc = v && running && !s;
    chk("pix_ready", {71'd0, pix_ready}, {71'd0, running && !s});
    chk("shift_en", {71'd0, shift_en}, {71'd0, acc});
    if (acc) chk("fifo_data", 72'(fifo_data), 72'(d));
    @(posedge clk);
    e_wv = 0; e_fd = 0;
    if (s) begin
      running = 1; F = G; lastg = -1; fk = 0;
    end else if (acc) begin
      H.push_back(d);
      r = fk / W; c = fk % W;
      if (r >= 2 && c >= 2) begin e_wv = 1; e_cr = r - 1; e_cc = c - 1; end
      lastg = G; G++; fk++;
      if (fk == W*HT) begin running = 0; e_fd = 1; end
    end
    #1;
    check_regs();
  endtask

  task automatic feed(input bit rnd_valid, input bit rnd_data);
    for (int n = 0; n < 400 && running; n++)
      step(1'b0, rnd_valid ? 1'($urandom) : 1'b1, rnd_data ? 8'($urandom) : 8'(fk));
    chk("frame_end_timeout", {71'd0, running}, 72'd0);
  endtask

  initial begin
    #2;
    #1;
    check_regs();
    chk("reset_pix_ready", {71'd0, pix_ready}, 72'd0);
    chk("reset_ctr", {67'd0, ctr_row, ctr_col}, 72'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Valid while idle is ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i + 40));

    // Frame of r*5+c with continuous valid.
    wv_cnt = 0;
    step(1'b1, 1'b0, 8'd0);
    feed(1'b0, 1'b0);
    chk("t1_windows", 72'(wv_cnt), 72'd6);
    chk("t1_first", {48'd0, 8'(first_cr), 8'(first_cc), 8'(first_v)}, {48'd0, 8'd1, 8'd1, 8'd6});
    chk("t1_last", {48'd0, 8'(last_cr), 8'(last_cc), 8'(last_v)}, {48'd0, 8'd2, 8'd3, 8'd13});
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i + 50));

    // Same frame, sparse valid.
    wv_cnt = 0;
    step(1'b1, 1'b0, 8'd0);
    feed(1'b1, 1'b0);
    chk("t2_windows", 72'(wv_cnt), 72'd6);
    chk("t2_first", {48'd0, 8'(first_cr), 8'(first_cc), 8'(first_v)}, {48'd0, 8'd1, 8'd1, 8'd6});
    chk("t2_last", {48'd0, 8'(last_cr), 8'(last_cc), 8'(last_v)}, {48'd0, 8'd2, 8'd3, 8'd13});

    // Restart after pixel 11, then a full random frame.
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(fk));
    wv_cnt = 0;
    step(1'b1, 1'b1, 8'd99);
    feed(1'b1, 1'b1);
    chk("t4_windows", 72'(wv_cnt), 72'd6);
    chk("t4_first_ctr", {56'd0, 8'(first_cr), 8'(first_cc)}, {56'd0, 8'd1, 8'd1});

    // Start collides with the last pixel: pixel dropped, new frame begins.
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 8'(fk));
    step(1'b1, 1'b1, 8'd19);
    feed(1'b1, 1'b1);

    // Asynchronous reset mid-frame.
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'($urandom));
    start = 1'b0; pix_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    running = 0; F = G; lastg = -1; fk = 0; e_wv = 0; e_fd = 0;
    check_regs();
    chk("rst_pix_ready", {71'd0, pix_ready}, 72'd0);
    chk("rst_shift_en", {71'd0, shift_en}, 72'd0);
    chk("rst_ctr", {67'd0, ctr_row, ctr_col}, 72'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
    wv_cnt = 0;
    step(1'b1, 1'b0, 8'd0);
    feed(1'b1, 1'b1);
    chk("t6_windows", 72'(wv_cnt), 72'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
